// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus 32-step shift-add multiplier that stalls decode while busy
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  RD,
    input  logic [2:0]  ALUctr,
    output logic [31:0] XM_ALUout,
    output logic [4:0]  XM_RD,
    output logic        XM_zero,
    output logic        stall
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [4:0]  rd_q;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] alu_res;
    logic [31:0] acc_next;
    // single-cycle ALU result; reserved codes and mul yield zero here
    always_comb begin
        alu_res = ALUctr == 3'd0 ? A + B :
                  ALUctr == 3'd1 ? A - B :
                  ALUctr == 3'd2 ? {31'd0, $signed(A) < $signed(B)} :
                  ALUctr == 3'd3 ? A & B :
                  ALUctr == 3'd4 ? A | B : 32'd0;
        acc_next = acc + (mplier[0] ? mcand : 32'd0);
    end
    assign stall = !rst && (state == IDLE ? ALUctr == 3'd5 : cnt != 5'd31);
    // pipeline register and multiplier sequencer; the last step's sum is emitted directly
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            rd_q      <= 5'd0;
            acc       <= 32'd0;
            mcand     <= 32'd0;
            mplier    <= 32'd0;
            XM_ALUout <= 32'd0;
            XM_RD     <= 5'd0;
            XM_zero   <= 1'b0;
        end else if (state == IDLE) begin
            if (ALUctr == 3'd5) begin
                state     <= MUL_BUSY;
                cnt       <= 5'd0;
                rd_q      <= RD;
                acc       <= 32'd0;
                mcand     <= A;
                mplier    <= B;
                XM_ALUout <= 32'd0;
                XM_RD     <= 5'd0;
                XM_zero   <= 1'b1;
            end else begin
                XM_ALUout <= alu_res;
                XM_RD     <= ALUctr <= 3'd4 ? RD : 5'd0;
                XM_zero   <= alu_res == 32'd0;
            end
        end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                state     <= IDLE;
                XM_ALUout <= acc_next;
                XM_RD     <= rd_q;
                XM_zero   <= acc_next == 32'd0;
            end else begin
                XM_ALUout <= 32'd0;
                XM_RD     <= 5'd0;
                XM_zero   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: table vectors, multiply/reset sequences and random ops against a reference model
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  RD;
    logic [2:0]  ALUctr;
    logic [31:0] XM_ALUout;
    logic [4:0]  XM_RD;
    logic        XM_zero;
    logic        stall;
    int total = 0;
    int bad = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .RD(RD), .ALUctr(ALUctr),
        .XM_ALUout(XM_ALUout), .XM_RD(XM_RD), .XM_zero(XM_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [31:0] out;
        logic [4:0]  xrd;
        logic        z;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [2:0] op);
        A = a;
        B = b;
        RD = rd;
        ALUctr = op;
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_single(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic [2:0] op);
        logic [31:0] e;
        drive(a, b, rd, op);
        #1;
        check("alu_stall", 32'(stall), 32'd0);
        tick();
        e = ref_alu(a, b, op);
        check("alu_out", XM_ALUout, e);
        check("alu_rd", 32'(XM_RD), op <= 3'd4 ? 32'(rd) : 32'd0);
        check("alu_zero", 32'(XM_zero), 32'(e == 32'd0));
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input bit scramble);
        int n;
        logic [31:0] p;
        n = 0;
        drive(a, b, rd, 3'd5);
        #1;
        while (stall && n < 40) begin
            n++;
            tick();
            check("mul_bubble_rd", 32'(XM_RD), 32'd0);
            check("mul_bubble_out", XM_ALUout, 32'd0);
            if (scramble) drive($urandom, $urandom, 5'($urandom), 3'($urandom));
            #1;
        end
        check("mul_stall_cycles", 32'(n), 32'd32);
        tick();
        p = a * b;
        check("mul_out", XM_ALUout, p);
        check("mul_rd", 32'(XM_RD), 32'(rd));
        check("mul_zero", 32'(XM_zero), 32'(p == 32'd0));
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        vecs = '{
            '{32'd7,          32'd5,          5'd3,  3'd0, 32'd12,         5'd3,  1'b0},
            '{32'hFFFFFFFF,   32'd1,          5'd1,  3'd2, 32'd1,          5'd1,  1'b0},
            '{32'd9,          32'd9,          5'd4,  3'd1, 32'd0,          5'd4,  1'b1},
            '{32'd5,          32'd5,          5'd9,  3'd6, 32'd0,          5'd0,  1'b1},
            '{32'd5,          32'd5,          5'd9,  3'd7, 32'd0,          5'd0,  1'b1},
            '{32'hFFFFFFFF,   32'd2,          5'd1,  3'd0, 32'd1,          5'd1,  1'b0},
            '{32'd0,          32'd1,          5'd2,  3'd1, 32'hFFFFFFFF,   5'd2,  1'b0},
            '{32'd1,          32'hFFFFFFFF,   5'd5,  3'd2, 32'd0,          5'd5,  1'b1},
            '{32'hF0F0F0F0,   32'h0FF00FF0,   5'd6,  3'd3, 32'h00F000F0,   5'd6,  1'b0},
            '{32'hF0F0F0F0,   32'h0F0F0F0F,   5'd7,  3'd4, 32'hFFFFFFFF,   5'd7,  1'b0},
            '{32'h80000000,   32'h7FFFFFFF,   5'd10, 3'd2, 32'd1,          5'd10, 1'b0},
            '{32'h12,         32'h21,         5'd0,  3'd4, 32'h33,         5'd0,  1'b0}
        };
        rst = 1'b1;
        drive(32'd6, 32'd7, 5'd8, 3'd5);
        tick();
        tick();
        check("rst_out", XM_ALUout, 32'd0);
        check("rst_rd", 32'(XM_RD), 32'd0);
        check("rst_zero", 32'(XM_zero), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].op);
            #1;
            check("vec_stall", 32'(stall), 32'd0);
            tick();
            check($sformatf("vec%0d_out", i), XM_ALUout, vecs[i].out);
            check($sformatf("vec%0d_rd", i), 32'(XM_RD), 32'(vecs[i].xrd));
            check($sformatf("vec%0d_zero", i), 32'(XM_zero), 32'(vecs[i].z));
        end
        do_mul(32'd6, 32'd7, 5'd8, 1'b0);
        if (XM_ALUout !== 32'd42) check("mul_6x7", XM_ALUout, 32'd42);
        do_mul(32'h10000, 32'h10000, 5'd2, 1'b0);
        do_single(32'd1, 32'd1, 5'd6, 3'd0);
        do_mul(32'd3, 32'd4, 5'd0, 1'b1);
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1);
        do_mul(32'h12345678, 32'h9ABCDEF1, 5'd17, 1'b0);
        drive(32'h1234, 32'h5678, 5'd7, 3'd5);
        tick();
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("abort_rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        check("abort_out", XM_ALUout, 32'd0);
        check("abort_rd", 32'(XM_RD), 32'd0);
        check("abort_zero", 32'(XM_zero), 32'd0);
        drive(32'd0, 32'd0, 5'd0, 3'd6);
        #1;
        check("abort_idle_stall", 32'(stall), 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (XM_RD != 5'd0 || XM_ALUout != 32'd0) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        repeat (150) begin
            ra = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
            rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd5) do_mul(ra, rb, 5'($urandom), 1'($urandom));
            else do_single(ra, rb, 5'($urandom), rop);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
